link_playback: RTL and testbench

Transmit-side counterpart of the link capture block. It holds a 32-bit × 8192-word playback memory that software loads. On an immediate request, an orbit-BX match, or a delayed L1A, it replays that memory onto the parallel link word stream. At all other times it drives the link alignment pattern. It sits in the 40 MHz word domain, upstream of the external serializer feeding the elink under test, so a receiver can align and then capture a known sequence.

---
 rtl/link_pkg.sv | 21 ++
 rtl/playback_ram.sv | 28 ++
 rtl/link_playback.sv | 142 ++++++++++++++
 tb/tb_link_playback.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/link_pkg.sv
// Shared types and constants for the link playback block: FSM states,
// playback mode encodings and the BX counter type.
package link_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    DELAY,
    PLAY
  } state_t;

  localparam logic [1:0] MODE_OFF = 2'd0;
  localparam logic [1:0] MODE_BX  = 2'd1;
  localparam logic [1:0] MODE_L1A = 2'd2;
  localparam logic [1:0] MODE_NOW = 2'd3;

  localparam int BX_WRAP_DEFAULT = 3563;

  typedef logic [11:0] bx_t;

endpackage

// File: rtl/playback_ram.sv
// Simple dual-port block RAM with registered reads on both ports. Port A
// loads and reads back; port B is the playback read. Collisions return old data.
module playback_ram #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              we_a,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [DATA_W-1:0] din_a,
  output logic [DATA_W-1:0] dout_a,
  input  logic [ADDR_W-1:0] addr_b,
  output logic [DATA_W-1:0] dout_b
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // NOTE: the array has no reset so it maps onto block RAM; contents are
  // whatever software loads, and reads of unloaded words are undefined.
  always_ff @(posedge clk) begin
    if (we_a) mem[addr_a] <= din_a;
    // NOTE: non-blocking assignments mean a same-cycle read sees the value
    // before this edge's write, which is the read-old collision behaviour.
    dout_a <= mem[addr_a];
    dout_b <= mem[addr_b];
  end

endmodule

// File: rtl/link_playback.sv
// Replays a software-loaded word memory onto the link word stream on an
// immediate, orbit-BX or delayed-L1A trigger; drives the align pattern otherwise.
module link_playback
  import link_pkg::*;
#(
  parameter int ADDR_W  = 13,
  parameter int BX_WRAP = BX_WRAP_DEFAULT
) (
  input  logic              clk40,
  input  logic              rst,
  input  logic [31:0]       align_pattern,
  input  logic [1:0]        playback_mode_in,
  input  logic              send,
  input  logic [ADDR_W-1:0] send_length,
  input  logic              L1A_in,
  input  logic [11:0]       L1A_offset_or_bx,
  input  logic              orbitSync,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_din,
  output logic [31:0]       mem_dout,
  output logic [31:0]       data_out,
  output logic [11:0]       bx_count,
  output logic              waiting_for_trig,
  output logic              sending,
  output logic              done
);

  state_t            state_q, state_d;
  logic [1:0]        mode_q;
  logic [ADDR_W-1:0] len_q, cnt_q, eff_len, rd_addr;
  bx_t               bx_q, dly_q;
  logic              send_q, send_edge;
  logic              arm, trig, load_dly;
  logic              sending_q, done_q;
  logic [31:0]       data_q, play_word;

  assign send_edge = send & ~send_q;

  // Word k is addressed in the cycle the previous word is read, so the
  // trigger edge already fetches word 0.
  assign rd_addr = (state_q == PLAY) ? cnt_q + ADDR_W'(1) : '0;

  playback_ram #(
    .ADDR_W(ADDR_W),
    .DATA_W(32)
  ) u_ram (
    .clk   (clk40),
    .we_a  (mem_we),
    .addr_a(mem_addr),
    .din_a (mem_din),
    .dout_a(mem_dout),
    .addr_b(rd_addr),
    .dout_b(play_word)
  );

  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves a value unassigned and infers a latch.
    state_d  = state_q;
    arm      = 1'b0;
    trig     = 1'b0;
    load_dly = 1'b0;
    eff_len  = (state_q == IDLE) ? send_length : len_q;
    case (state_q)
      IDLE: begin
        if (send_edge && playback_mode_in != MODE_OFF) begin
          arm = 1'b1;
          if (playback_mode_in == MODE_NOW) trig = 1'b1;
          else                              state_d = ARMED;
        end
      end
      ARMED: begin
        if (playback_mode_in == MODE_OFF) begin
          state_d = IDLE;
        end else if (mode_q == MODE_BX && bx_q == L1A_offset_or_bx) begin
          trig = 1'b1;
        end else if (mode_q == MODE_L1A && L1A_in) begin
          if (L1A_offset_or_bx == '0) begin
            trig = 1'b1;
          end else begin
            state_d  = DELAY;
            load_dly = 1'b1;
          end
        end
      end
      DELAY: begin
        if (playback_mode_in == MODE_OFF) state_d = IDLE;
        else if (dly_q == '0)             trig = 1'b1;
      end
      PLAY: begin
        if (cnt_q == len_q - ADDR_W'(1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (trig) state_d = (eff_len == '0) ? IDLE : PLAY;
  end

  always_ff @(posedge clk40) begin
    if (rst) begin
      state_q   <= IDLE;
      mode_q    <= MODE_OFF;
      len_q     <= '0;
      cnt_q     <= '0;
      dly_q     <= '0;
      bx_q      <= '0;
      send_q    <= 1'b0;
      sending_q <= 1'b0;
      done_q    <= 1'b0;
      data_q    <= '0;
    end else begin
      state_q <= state_d;
      send_q  <= send;

      if (orbitSync || bx_q == bx_t'(BX_WRAP)) bx_q <= '0;
      else                                      bx_q <= bx_q + 12'd1;

      if (arm) begin
        mode_q <= playback_mode_in;
        len_q  <= send_length;
      end

      // Loading offset-1 lands the zero count on the offset-th cycle after L1A.
      if (load_dly)               dly_q <= L1A_offset_or_bx - 12'd1;
      else if (state_q == DELAY)  dly_q <= dly_q - 12'd1;

      if (trig)                  cnt_q <= '0;
      else if (state_q == PLAY)  cnt_q <= cnt_q + ADDR_W'(1);

      sending_q <= (state_q == PLAY);
      data_q    <= (state_q == PLAY) ? play_word : align_pattern;
      done_q    <= (sending_q && state_q != PLAY) || (trig && eff_len == '0);
    end
  end

  assign data_out         = data_q;
  assign bx_count         = bx_q;
  assign sending          = sending_q;
  assign done             = done_q;
  assign waiting_for_trig = (state_q == ARMED) || (state_q == DELAY);

endmodule

// File: tb/tb_link_playback.sv
// Randomized scoreboard bench for link_playback: stimulus pushes expected words,
// done pulses and readbacks into queues; a negedge monitor pops and compares.
module tb_link_playback;
  localparam int ADDR_W  = 13;
  localparam int BX_WRAP = 3563;
  localparam int NEVER   = 1 << 30;
  localparam logic [31:0] ALIGN = 32'haccccccc;

  typedef struct {
    int          cyc;
    logic [31:0] word;
  } exp_t;

  logic              clk40 = 1'b0;
  logic              rst;
  logic [31:0]       align_pattern;
  logic [1:0]        playback_mode_in;
  logic              send;
  logic [ADDR_W-1:0] send_length;
  logic              L1A_in;
  logic [11:0]       L1A_offset_or_bx;
  logic              orbitSync;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_din;
  logic [31:0]       mem_dout;
  logic [31:0]       data_out;
  logic [11:0]       bx_count;
  logic              waiting_for_trig;
  logic              sending;
  logic              done;

  link_playback #(.ADDR_W(ADDR_W), .BX_WRAP(BX_WRAP)) dut (
    .clk40           (clk40),
    .rst             (rst),
    .align_pattern   (align_pattern),
    .playback_mode_in(playback_mode_in),
    .send            (send),
    .send_length     (send_length),
    .L1A_in          (L1A_in),
    .L1A_offset_or_bx(L1A_offset_or_bx),
    .orbitSync       (orbitSync),
    .mem_we          (mem_we),
    .mem_addr        (mem_addr),
    .mem_din         (mem_din),
    .mem_dout        (mem_dout),
    .data_out        (data_out),
    .bx_count        (bx_count),
    .waiting_for_trig(waiting_for_trig),
    .sending         (sending),
    .done            (done)
  );

  always #5 clk40 = ~clk40;

  int cyc = 0;
  always @(posedge clk40) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  exp_t        word_q[$];
  exp_t        rd_q[$];
  int          done_q[$];
  logic [31:0] model [0:(1<<ADDR_W)-1];

  bit mon_en     = 1'b0;
  bit prev_rst   = 1'b1;
  bit prev_orbit = 1'b0;
  int anchor_cyc = 0;
  int anchor_val = 0;
  int wlo = -10;
  int whi = -20;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
  endtask

  // Monitor: BX from the last orbit/reset anchor, words and done from queues.
  always @(negedge clk40) begin
    if (mon_en) begin
      if (prev_rst || prev_orbit) begin
        anchor_cyc = cyc;
        anchor_val = 0;
      end
      check("bx_count", {20'd0, bx_count}, (anchor_val + cyc - anchor_cyc) % (BX_WRAP + 1));

      while (word_q.size() > 0 && word_q[0].cyc < cyc) begin
        check("word_cycle", cyc, word_q[0].cyc);
        void'(word_q.pop_front());
      end
      if (word_q.size() > 0 && word_q[0].cyc == cyc) begin
        check("sending", {31'd0, sending}, 32'd1);
        check("play_word", data_out, word_q[0].word);
        void'(word_q.pop_front());
      end else begin
        check("sending", {31'd0, sending}, 32'd0);
        check("idle_word", data_out, prev_rst ? 32'd0 : ALIGN);
      end

      while (done_q.size() > 0 && done_q[0] < cyc) begin
        check("done_cycle", cyc, done_q[0]);
        void'(done_q.pop_front());
      end
      if (done_q.size() > 0 && done_q[0] == cyc) begin
        check("done", {31'd0, done}, 32'd1);
        void'(done_q.pop_front());
      end else begin
        check("done", {31'd0, done}, 32'd0);
      end

      while (rd_q.size() > 0 && rd_q[0].cyc < cyc) begin
        check("readback_cycle", cyc, rd_q[0].cyc);
        void'(rd_q.pop_front());
      end
      if (rd_q.size() > 0 && rd_q[0].cyc == cyc) begin
        check("mem_dout", mem_dout, rd_q[0].word);
        void'(rd_q.pop_front());
      end

      if (cyc >= wlo && cyc <= whi + 1)
        check("waiting_for_trig", {31'd0, waiting_for_trig}, {31'd0, cyc <= whi});
    end
    prev_rst   = rst;
    prev_orbit = orbitSync;
  end

  task automatic tick();
    @(posedge clk40);
    #1;
  endtask

  task automatic run_to(input int c);
    while (cyc < c) tick();
  endtask

  task automatic write_mem(input int a, input logic [31:0] d);
    mem_we   = 1'b1;
    mem_addr = ADDR_W'(a);
    mem_din  = d;
    tick();
    mem_we   = 1'b0;
    model[a] = d;
  endtask

  task automatic read_back(input int a);
    mem_we   = 1'b0;
    mem_addr = ADDR_W'(a);
    rd_q.push_back('{cyc + 1, model[a]});
    tick();
  endtask

  // Trigger at cycle t: word k at t+2+k, done at t+2+n (t+1 when n is 0);
  // anything scheduled after cycle cut is lost to a reset.
  task automatic push_play(input int t, input int n, input int cut);
    for (int k = 0; k < n; k++)
      if (t + 2 + k <= cut) word_q.push_back('{t + 2 + k, model[k]});
    if (n == 0) done_q.push_back(t + 1);
    else if (t + 2 + n <= cut) done_q.push_back(t + 2 + n);
  endtask

  task automatic do_send(input logic [1:0] mode, input int len, output int t);
    playback_mode_in = mode;
    send_length      = ADDR_W'(len);
    send             = 1'b1;
    t                = cyc;
    if (mode == 2'd3) push_play(t, len, NEVER);
    tick();
    send = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t, s, l, n, c0;
    logic [31:0] v;
    rst = 1'b1; align_pattern = ALIGN; playback_mode_in = 2'd0; send = 1'b0;
    send_length = '0; L1A_in = 1'b0; L1A_offset_or_bx = '0; orbitSync = 1'b0;
    mem_we = 1'b0; mem_addr = '0; mem_din = '0;
    tick();
    mon_en = 1'b1;
    tick();
    @(negedge clk40);
    check("reset_data_out", data_out, 32'd0);
    check("reset_waiting", {31'd0, waiting_for_trig}, 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // Immediate playback of a ramp, plus random load/readback.
    for (int i = 0; i < 16; i++) write_mem(i, 32'h10000000 + i);
    for (int i = 100; i < 104; i++) write_mem(i, $urandom);
    for (int i = 100; i < 104; i++) read_back(i);
    do_send(2'd3, 16, t);
    run_to(t + 22);

    // Orbit-BX trigger with orbitSync coinciding with the match.
    write_mem(0, 32'hdeadbeef);
    write_mem(1, 32'hdeadbeef);
    c0 = cyc;
    orbitSync = 1'b1; tick(); orbitSync = 1'b0;
    L1A_offset_or_bx = 12'hca;
    run_to(c0 + 10);
    do_send(2'd1, 2, s);
    t = c0 + 1 + 12'hca;
    run_to(t);
    orbitSync = 1'b1;
    push_play(t, 2, NEVER);
    tick(); orbitSync = 1'b0;
    send = 1'b1; tick(); send = 1'b0;
    run_to(t + 6);
    @(negedge clk40);
    check("no_rearm", {31'd0, waiting_for_trig}, 32'd0);
    run_to(t + 10);

    // L1A with offset 0x20, ignoring L1A and send during DELAY.
    n = $urandom_range(1, 8);
    for (int i = 0; i < n; i++) write_mem(i, $urandom);
    L1A_offset_or_bx = 12'h20;
    do_send(2'd2, n, s);
    run_to(s + 3);
    l = cyc; wlo = l; whi = l + 32;
    L1A_in = 1'b1;
    push_play(l + 32, n, NEVER);
    tick(); L1A_in = 1'b0;
    run_to(l + 5);
    L1A_in = 1'b1; send = 1'b1; tick(); L1A_in = 1'b0; send = 1'b0;
    run_to(l + 40 + n);

    // L1A with offset 0: the L1A cycle is the trigger.
    L1A_offset_or_bx = 12'h000;
    do_send(2'd2, n, s);
    run_to(s + 2);
    l = cyc; wlo = l; whi = l;
    L1A_in = 1'b1;
    push_play(l, n, NEVER);
    tick(); L1A_in = 1'b0;
    run_to(l + n + 6);

    // Zero length: done only, no words.
    do_send(2'd3, 0, t);
    run_to(t + 5);

    // Abort: armed in BX mode on an unreachable BX, then mode forced off.
    L1A_offset_or_bx = 12'hfff;
    do_send(2'd1, 4, s);
    tick(); tick();
    @(negedge clk40);
    check("armed_waiting", {31'd0, waiting_for_trig}, 32'd1);
    playback_mode_in = 2'd0;
    tick(); tick();
    @(negedge clk40);
    check("abort_waiting", {31'd0, waiting_for_trig}, 32'd0);
    run_to(cyc + 10);

    // Write to word 5 in the cycle it is read: old data goes out.
    for (int i = 0; i < 8; i++) write_mem(i, $urandom);
    do_send(2'd3, 8, t);
    run_to(t + 5);
    v = $urandom;
    write_mem(5, v);
    run_to(t + 14);
    read_back(5);
    tick();

    // Reset in the middle of playback, then a full BX wrap without orbitSync.
    for (int i = 0; i < 16; i++) write_mem(i, $urandom);
    do_send(2'd3, 16, t);
    word_q.delete(); done_q.delete();
    push_play(t, 16, t + 5);
    run_to(t + 5);
    rst = 1'b1; tick(); rst = 1'b0;
    run_to(cyc + BX_WRAP + 40);

    check("words_left", word_q.size(), 32'd0);
    check("dones_left", done_q.size(), 32'd0);
    check("reads_left", rd_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
